cache_l1_wt_param: RTL and testbench

Parametrised direct-mapped, write-through L1 data cache, one per core, between the core's load/store unit and the shared data-memory/L2 port. Generalises the current fixed 10-bit-address L1 with configurable geometry and a variable-latency req/ack memory handshake instead of a fixed one-cycle fill. It also adds snoop invalidation for multicore coherence and saturating hit/miss counters.

---
 rtl/cache_l1_pkg.sv | 21 ++
 rtl/l1_byte_lane_unit.sv | 68 ++++++
 rtl/cache_l1_wt_param.sv | 173 +++++++++++++++++
 tb/tb_cache_l1_wt_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_l1_pkg.sv
// rtl/cache_l1_pkg.sv - shared types and funct3 codes for the L1 write-through cache
package cache_l1_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    function automatic logic mask_legal(input logic [2:0] mask);
        return (mask == LB) || (mask == LH) || (mask == LW) ||
               (mask == LBU) || (mask == LHU);
    endfunction

endpackage

// File: rtl/l1_byte_lane_unit.sv
// rtl/l1_byte_lane_unit.sv - load extract/sign-extend and store lane merge for one word
module l1_byte_lane_unit
    import cache_l1_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_mask,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged,
    output logic [31:0] o_lane_wdata,
    output logic [3:0]  o_be
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_word >> {i_offset, 3'b000};
    assign w_byte  = w_shift[7:0];
    // Halfword accesses only look at offset bit 1; a misaligned bit 0 is ignored.
    assign w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_load_data = 32'h0;
        case (i_mask)
            LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load_data = {24'h0, w_byte};
            LH:      o_load_data = {{16{w_half[15]}}, w_half};
            LHU:     o_load_data = {16'h0, w_half};
            LW:      o_load_data = i_word;
            default: o_load_data = 32'h0;
        endcase
    end

    always_comb begin
        o_be         = 4'b0000;
        o_lane_wdata = 32'h0;
        if (mask_legal(i_mask)) begin
            case (i_mask[1:0])
                2'b00: begin
                    o_be         = 4'b0001 << i_offset;
                    o_lane_wdata = {24'h0, i_wdata[7:0]} << {i_offset, 3'b000};
                end
                2'b01: begin
                    o_be         = i_offset[1] ? 4'b1100 : 4'b0011;
                    o_lane_wdata = i_offset[1] ? {i_wdata[15:0], 16'h0} : {16'h0, i_wdata[15:0]};
                end
                2'b10: begin
                    o_be         = 4'b1111;
                    o_lane_wdata = i_wdata;
                end
                default: begin
                    o_be         = 4'b0000;
                    o_lane_wdata = 32'h0;
                end
            endcase
        end
    end

    always_comb begin
        o_merged = i_word;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) o_merged[i*8 +: 8] = o_lane_wdata[i*8 +: 8];
        end
    end

endmodule

// File: rtl/cache_l1_wt_param.sv
// rtl/cache_l1_wt_param.sv - direct-mapped write-through L1 data cache with snoop invalidate
module cache_l1_wt_param
    import cache_l1_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [2:0]        cpu_mask,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 2 ** INDEX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } line_t;

    state_t             r_state;
    state_t             w_next;
    logic [LINES-1:0]   r_valid;
    line_t              r_lines [LINES];
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic               r_refill_done;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_sidx;
    logic [TAG_W-1:0]   w_stag;
    logic               w_legal;
    logic               w_hit;
    logic               w_snoop_hit;
    logic               w_snoop_same;
    logic               w_fill;
    logic               w_wr_done;
    logic               w_alloc;
    logic               w_merge;
    logic               w_cnt_hit;
    logic               w_cnt_miss;
    logic [31:0]        w_load_data;
    logic [31:0]        w_merged;
    logic [31:0]        w_lane_wdata;
    logic [3:0]         w_be;
    logic               w_unused_snoop;

    assign w_idx   = cpu_addr[INDEX_W+1:2];
    assign w_tag   = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign w_sidx  = snoop_addr[INDEX_W+1:2];
    assign w_stag  = snoop_addr[ADDR_W-1:INDEX_W+2];
    assign w_legal = mask_legal(cpu_mask);
    assign w_hit   = r_valid[w_idx] && (r_lines[w_idx].tag == w_tag);
    assign w_unused_snoop = ^snoop_addr[1:0];

    assign w_snoop_hit  = snoop_inv && r_valid[w_sidx] && (r_lines[w_sidx].tag == w_stag);
    // A snoop aimed at the line being filled or allocated this edge must also kill it.
    assign w_snoop_same = snoop_inv && (w_sidx == w_idx) && (w_stag == w_tag);

    assign w_fill    = (r_state == RD_MISS) && mem_ack;
    assign w_wr_done = (r_state == WR_THRU) && mem_ack;
    assign w_alloc   = w_wr_done && !w_hit && (cpu_mask[1:0] == 2'b10);
    assign w_merge   = w_wr_done && w_hit;

    l1_byte_lane_unit u_lane (
        .i_word       (r_lines[w_idx].data),
        .i_offset     (cpu_addr[1:0]),
        .i_mask       (cpu_mask),
        .i_wdata      (cpu_wdata),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged),
        .o_lane_wdata (w_lane_wdata),
        .o_be         (w_be)
    );

    assign mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata = w_lane_wdata;
    assign mem_be    = (r_state == WR_THRU) ? w_be : 4'hF;
    assign hit_cnt   = r_hit_cnt;
    assign miss_cnt  = r_miss_cnt;

    // Outputs are held quiet while reset is asserted so an abandoned miss drops at once.
    always_comb begin
        w_next     = r_state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        cpu_rdata  = 32'h0;
        w_cnt_hit  = 1'b0;
        w_cnt_miss = 1'b0;
        if (reset) begin
            case (r_state)
                IDLE: begin
                    if (cpu_rd_en && w_legal) begin
                        if (w_hit) begin
                            cpu_rdata = w_load_data;
                            w_cnt_hit = !r_refill_done;
                        end else begin
                            stall      = 1'b1;
                            w_cnt_miss = 1'b1;
                            w_next     = RD_MISS;
                        end
                    end else if (cpu_wr_en && !cpu_rd_en && w_legal) begin
                        stall  = 1'b1;
                        w_next = WR_THRU;
                    end
                end
                RD_MISS: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                    if (mem_ack) w_next = IDLE;
                end
                WR_THRU: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    stall   = !mem_ack;
                    if (mem_ack) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_refill_done <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_refill_done <= w_fill;
            if (w_cnt_hit && (r_hit_cnt != {CNT_W{1'b1}}))
                r_hit_cnt <= r_hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_cnt_miss && (r_miss_cnt != {CNT_W{1'b1}}))
                r_miss_cnt <= r_miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_snoop_hit)
                r_valid[w_sidx] <= 1'b0;
            if (w_fill || w_alloc)
                r_valid[w_idx] <= !w_snoop_same;
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill)
            r_lines[w_idx] <= '{tag: w_tag, data: mem_rdata};
        else if (w_alloc)
            r_lines[w_idx] <= '{tag: w_tag, data: cpu_wdata};
        else if (w_merge)
            r_lines[w_idx].data <= w_merged;
    end

endmodule

// File: tb/tb_cache_l1_wt_param.sv
// tb/tb_cache_l1_wt_param.sv - directed self-checking bench for cache_l1_wt_param
module tb_cache_l1_wt_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd_en, cpu_wr_en;
    logic [2:0]  cpu_mask;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        snoop_inv;
    logic [9:0]  snoop_addr;

    logic [31:0] cpu_rdata, cpu_rdata_s;
    logic        stall, stall_s;
    logic        mem_req, mem_req_s, mem_we, mem_we_s;
    logic [9:0]  mem_addr, mem_addr_s;
    logic [31:0] mem_wdata, mem_wdata_s;
    logic [3:0]  mem_be, mem_be_s;
    logic [15:0] hit_cnt, miss_cnt;
    logic [1:0]  hit_cnt_s, miss_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_l1_wt_param #(.ADDR_W(10), .INDEX_W(6), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_mask(cpu_mask), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .snoop_inv(snoop_inv),
        .snoop_addr(snoop_addr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_l1_wt_param #(.ADDR_W(10), .INDEX_W(6), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_mask(cpu_mask), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_s), .stall(stall_s), .mem_req(mem_req_s), .mem_we(mem_we_s),
        .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_be(mem_be_s),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .snoop_inv(snoop_inv),
        .snoop_addr(snoop_addr), .hit_cnt(hit_cnt_s), .miss_cnt(miss_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  mask;
        logic [9:0]  addr;
        logic [31:0] exp;
        string       tag;
    } ld_vec_t;

    ld_vec_t ld_vecs[4];

    initial begin
        ld_vecs[0] = '{3'b000, 10'h107, 32'hFFFFFFDE, "lb_107"};
        ld_vecs[1] = '{3'b100, 10'h107, 32'h000000DE, "lbu_107"};
        ld_vecs[2] = '{3'b101, 10'h106, 32'h0000DEAD, "lhu_106"};
        ld_vecs[3] = '{3'b001, 10'h104, 32'hFFFFBEEF, "lh_104"};

        reset = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_mask = 3'b010;
        cpu_addr = '0; cpu_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        snoop_inv = 1'b0; snoop_addr = '0;
        tick; tick;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_hit", {16'h0, hit_cnt}, 32'h0);
        check("rst_miss", {16'h0, miss_cnt}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        reset = 1'b1;
        tick;

        // First load miss, acked after three RD_MISS cycles
        cpu_rd_en = 1'b1; cpu_mask = 3'b010; cpu_addr = 10'h104;
        #1 check("miss_stall", {31'h0, stall}, 32'h1);
        tick;
        check("rdmiss_req", {31'h0, mem_req}, 32'h1);
        check("rdmiss_we", {31'h0, mem_we}, 32'h0);
        check("rdmiss_addr", {22'h0, mem_addr}, 32'h104);
        check("rdmiss_miss_cnt", {16'h0, miss_cnt}, 32'h1);
        tick; tick;
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 check("ack_stall", {31'h0, stall}, 32'h1);
        tick;
        mem_ack = 1'b0;
        #1 check("refill_stall", {31'h0, stall}, 32'h0);
        check("refill_rdata", cpu_rdata, 32'hDEADBEEF);
        check("refill_req", {31'h0, mem_req}, 32'h0);
        tick;
        check("refill_no_hit", {16'h0, hit_cnt}, 32'h0);
        check("hit_rdata", cpu_rdata, 32'hDEADBEEF);
        check("hit_stall", {31'h0, stall}, 32'h0);
        tick;
        check("hit_cnt1", {16'h0, hit_cnt}, 32'h1);

        foreach (ld_vecs[i]) begin
            cpu_mask = ld_vecs[i].mask; cpu_addr = ld_vecs[i].addr;
            #1 check(ld_vecs[i].tag, cpu_rdata, ld_vecs[i].exp);
            tick;
        end
        check("hit_cnt5", {16'h0, hit_cnt}, 32'h5);
        check("sat_hit", {30'h0, hit_cnt_s}, 32'h3);

        // Byte store hit, merged into the line
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b1; cpu_mask = 3'b000;
        cpu_addr = 10'h105; cpu_wdata = 32'h11;
        #1 check("sb_stall", {31'h0, stall}, 32'h1);
        tick;
        check("sb_req", {31'h0, mem_req}, 32'h1);
        check("sb_we", {31'h0, mem_we}, 32'h1);
        check("sb_be", {28'h0, mem_be}, 32'h2);
        check("sb_wdata", mem_wdata, 32'h00001100);
        check("sb_addr", {22'h0, mem_addr}, 32'h104);
        mem_ack = 1'b1;
        #1 check("sb_ack_stall", {31'h0, stall}, 32'h0);
        tick;
        mem_ack = 1'b0; cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b1; cpu_mask = 3'b010; cpu_addr = 10'h104;
        #1 check("sb_merge_rdata", cpu_rdata, 32'hDEAD11EF);
        check("sb_merge_stall", {31'h0, stall}, 32'h0);
        tick;
        cpu_rd_en = 1'b0;

        // Halfword store miss: written through, not allocated
        cpu_wr_en = 1'b1; cpu_mask = 3'b001; cpu_addr = 10'h208; cpu_wdata = 32'h1234;
        tick;
        check("sh_be", {28'h0, mem_be}, 32'h3);
        check("sh_wdata", mem_wdata, 32'h00001234);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0; cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b1; cpu_mask = 3'b010; cpu_addr = 10'h208;
        #1 check("sh_no_alloc", {31'h0, stall}, 32'h1);
        tick;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick;
        mem_ack = 1'b0;
        #1 check("fill208_rdata", cpu_rdata, 32'hCAFEF00D);
        check("miss_cnt2", {16'h0, miss_cnt}, 32'h2);
        tick;
        cpu_rd_en = 1'b0;

        // Word store miss allocates
        cpu_wr_en = 1'b1; cpu_mask = 3'b010; cpu_addr = 10'h30C; cpu_wdata = 32'h12345678;
        tick;
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0; cpu_wr_en = 1'b0; cpu_rd_en = 1'b1;
        #1 check("sw_alloc_stall", {31'h0, stall}, 32'h0);
        check("sw_alloc_rdata", cpu_rdata, 32'h12345678);
        tick;
        cpu_rd_en = 1'b0;

        // Snoop invalidation, then snoop colliding with a refill
        snoop_inv = 1'b1; snoop_addr = 10'h104;
        tick;
        snoop_inv = 1'b0; cpu_rd_en = 1'b1; cpu_addr = 10'h104;
        #1 check("snoop_inv_miss", {31'h0, stall}, 32'h1);
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA; snoop_inv = 1'b1; snoop_addr = 10'h104;
        tick;
        mem_ack = 1'b0; snoop_inv = 1'b0;
        #1 check("snoop_refill_remiss", {31'h0, stall}, 32'h1);
        tick;
        check("miss_cnt4", {16'h0, miss_cnt}, 32'h4);
        check("remiss_req", {31'h0, mem_req}, 32'h1);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        #1 check("remiss_rdata", cpu_rdata, 32'h55AA55AA);
        check("remiss_stall", {31'h0, stall}, 32'h0);
        tick;

        // Illegal mask: no action
        cpu_mask = 3'b011;
        #1 check("illegal_stall", {31'h0, stall}, 32'h0);
        check("illegal_rdata", cpu_rdata, 32'h0);
        tick;
        check("illegal_no_cnt", {16'h0, hit_cnt}, 32'h7);

        // Load and store together: load wins
        cpu_mask = 3'b010; cpu_wr_en = 1'b1; cpu_wdata = 32'h0;
        #1 check("prio_stall", {31'h0, stall}, 32'h0);
        check("prio_rdata", cpu_rdata, 32'h55AA55AA);
        tick;
        check("prio_noreq", {31'h0, mem_req}, 32'h0);
        check("hit_cnt8", {16'h0, hit_cnt}, 32'h8);
        cpu_wr_en = 1'b0;

        // Asynchronous reset in the middle of a refill
        cpu_addr = 10'h0CC;
        tick;
        check("pre_rst_req", {31'h0, mem_req}, 32'h1);
        #2 reset = 1'b0;
        #1 check("async_rst_req", {31'h0, mem_req}, 32'h0);
        check("async_rst_stall", {31'h0, stall}, 32'h0);
        check("async_rst_hit", {16'h0, hit_cnt}, 32'h0);
        check("async_rst_miss", {16'h0, miss_cnt}, 32'h0);
        check("async_rst_sat", {30'h0, hit_cnt_s}, 32'h0);
        tick;
        reset = 1'b1; cpu_addr = 10'h104;
        #1 check("post_rst_invalid", {31'h0, stall}, 32'h1);
        tick;
        check("post_rst_miss", {16'h0, miss_cnt}, 32'h1);
        cpu_rd_en = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
